// File: rtl/core_output_serializer_if.sv
// Beat stream from the output serializer to the downstream buffer / memory writer.
// One beat carries one core chunk plus its index and an end-of-frame marker.
interface core_output_serializer_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK_SIZE = 4,
  parameter int unsigned NUM_CORES  = 2
);
  localparam int unsigned Beat = WIDTH * CHUNK_SIZE;
  localparam int unsigned IdxW = $clog2(NUM_CORES);

  logic            out_valid;
  logic            out_ready;
  logic [Beat-1:0] out_data;
  logic            out_last;
  logic [IdxW-1:0] out_idx;

  // Serializer side
  modport master (
    output out_valid,
    output out_data,
    output out_last,
    output out_idx,
    input  out_ready
  );

  // Consumer side
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_idx,
    output out_ready
  );
endinterface

// File: rtl/core_output_serializer.sv
// Captures the concatenated per-core result bus on a rising acc_done and streams it
// out one core chunk per beat (chunk 0 first). Edges that arrive while a frame is
// still held are dropped and flagged in a sticky overflow bit.
module core_output_serializer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK_SIZE = 4,
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en,
  input  logic                                   acc_done,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0]  in_data,
  core_output_serializer_if.master               out_if,
  output logic                                   busy,
  output logic                                   overflow,
  output logic [CNT_WIDTH-1:0]                   frame_count
);

  localparam int unsigned Beat = WIDTH * CHUNK_SIZE;
  localparam int unsigned IdxW = $clog2(NUM_CORES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CORES - 1);

  localparam logic StIdle = 1'b0;
  localparam logic StSend = 1'b1;

  logic                           state_q, state_d;
  logic [IdxW-1:0]                idx_q, idx_d;
  logic [NUM_CORES-1:0][Beat-1:0] shadow_q, shadow_d;
  logic                           acc_done_q;  // previous-cycle acc_done for edge detect
  logic                           ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;

  logic cap;
  logic sending;
  logic hs;
  logic at_last;

  assign cap     = en & acc_done & ~acc_done_q;
  assign sending = (state_q == StSend);
  assign hs      = sending & out_if.out_ready;
  assign at_last = (idx_q == LastIdx);

  // Next-state: capture, beat advance, back-to-back reload and overflow detection
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (cap) begin
          shadow_d = in_data;
          idx_d    = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (hs && !at_last) begin
          idx_d = idx_q + IdxW'(1);
        end else if (hs && at_last) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          idx_d = '0;
          if (cap) begin
            // New frame lands exactly as the old one finishes: no gap, no loss
            shadow_d = in_data;
          end else begin
            state_d = StIdle;
          end
        end
        if (cap && !(hs && at_last)) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      shadow_q   <= '0;
      acc_done_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      acc_done_q <= acc_done;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs are forced to zero outside SEND so the stream is quiet when idle
  assign out_if.out_valid = sending;
  assign out_if.out_data  = sending ? shadow_q[idx_q] : '0;
  assign out_if.out_idx   = sending ? idx_q : '0;
  assign out_if.out_last  = sending & at_last;
  assign busy             = sending;
  assign overflow         = ovf_q;
  assign frame_count      = cnt_q;

endmodule

// File: tb/tb_core_output_serializer.sv
// Scoreboard bench for core_output_serializer: each capture pushes its expected beats,
// a negedge monitor pops and compares every handshaked beat and checks stall stability.
module tb_core_output_serializer;

  localparam int unsigned Width     = 16;
  localparam int unsigned ChunkSize = 4;
  localparam int unsigned NumCores  = 2;
  localparam int unsigned CntWidth  = 16;
  localparam int unsigned Beat      = Width * ChunkSize;
  localparam int unsigned IdxW      = $clog2(NumCores);

  typedef struct packed {
    logic [Beat-1:0] data;
    logic [IdxW-1:0] idx;
    logic            last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     en;
  logic                     acc_done;
  logic [Beat*NumCores-1:0] in_data;
  logic                     busy;
  logic                     overflow;
  logic [CntWidth-1:0]      frame_count;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  core_output_serializer_if #(
    .WIDTH     (Width),
    .CHUNK_SIZE(ChunkSize),
    .NUM_CORES (NumCores)
  ) out_if ();

  core_output_serializer #(
    .WIDTH     (Width),
    .CHUNK_SIZE(ChunkSize),
    .NUM_CORES (NumCores),
    .CNT_WIDTH (CntWidth)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .acc_done   (acc_done),
    .in_data    (in_data),
    .out_if     (out_if.master),
    .busy       (busy),
    .overflow   (overflow),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [Beat*NumCores-1:0] d);
    beat_t b;
    for (int i = 0; i < NumCores; i++) begin
      b.data = d[i*Beat +: Beat];
      b.idx  = IdxW'(i);
      b.last = (i == NumCores - 1);
      sb.push_back(b);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      cyc(1);
      n++;
    end
    if (n >= 100) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare handshaked beats against the scoreboard, and stalled beats against its head
  always @(negedge clk) begin
    if (rst_n && out_if.out_valid) begin
      if (out_if.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_beat", 64'(out_if.out_valid), 64'd0);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check_eq("beat_data", out_if.out_data, e.data);
          check_eq("beat_idx", 64'(out_if.out_idx), 64'(e.idx));
          check_eq("beat_last", 64'(out_if.out_last), 64'(e.last));
        end
      end else if (sb.size() != 0) begin
        check_eq("stall_data", out_if.out_data, sb[0].data);
        check_eq("stall_idx", 64'(out_if.out_idx), 64'(sb[0].idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [Beat*NumCores-1:0] fa, fb;

    rst_n = 1'b0;
    en = 1'b0;
    acc_done = 1'b0;
    in_data = '0;
    out_if.out_ready = 1'b0;
    cyc(2);
    check_eq("rst_valid", 64'(out_if.out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_count", 64'(frame_count), 64'd0);
    check_eq("rst_data", out_if.out_data, 64'd0);
    rst_n = 1'b1;
    cyc(1);

    // Basic frame, ready held high
    fa = {64'hBBBB_BBBB_BBBB_0002, 64'hAAAA_AAAA_AAAA_0001};
    in_data = fa;
    en = 1'b1;
    out_if.out_ready = 1'b1;
    acc_done = 1'b1;
    push_frame(fa);
    cyc(1);
    in_data = {$urandom, $urandom, $urandom, $urandom};  // upstream changes after capture
    check_eq("basic_valid_t1", 64'(out_if.out_valid), 64'd1);
    check_eq("basic_idx0", 64'(out_if.out_idx), 64'd0);
    cyc(NumCores - 1);
    check_eq("basic_last", 64'(out_if.out_last), 64'd1);
    cyc(1);
    check_eq("basic_valid_drop", 64'(out_if.out_valid), 64'd0);
    check_eq("basic_count", 64'(frame_count), 64'd1);
    check_eq("basic_busy", 64'(busy), 64'd0);
    check_eq("idle_data", out_if.out_data, 64'd0);
    acc_done = 1'b0;
    cyc(1);

    // Back-pressure: ready low for 3 cycles after first valid
    fa = {$urandom, $urandom, $urandom, $urandom};
    in_data = fa;
    out_if.out_ready = 1'b0;
    acc_done = 1'b1;
    push_frame(fa);
    cyc(1);
    acc_done = 1'b0;
    cyc(3);
    out_if.out_ready = 1'b1;
    wait_drain();
    check_eq("bp_overflow", 64'(overflow), 64'd0);
    check_eq("bp_count", 64'(frame_count), 64'd2);

    // Back-to-back: new edge coincides with last-beat handshake
    fa = {$urandom, $urandom, $urandom, $urandom};
    fb = {$urandom, $urandom, $urandom, $urandom};
    in_data = fa;
    acc_done = 1'b1;
    push_frame(fa);
    cyc(1);
    acc_done = 1'b0;
    cyc(NumCores - 1);
    check_eq("b2b_at_last", 64'(out_if.out_last), 64'd1);
    in_data = fb;
    acc_done = 1'b1;
    push_frame(fb);
    cyc(1);
    check_eq("b2b_valid", 64'(out_if.out_valid), 64'd1);
    check_eq("b2b_idx0", 64'(out_if.out_idx), 64'd0);
    acc_done = 1'b0;
    wait_drain();
    check_eq("b2b_overflow", 64'(overflow), 64'd0);
    check_eq("b2b_count", 64'(frame_count), 64'd4);

    // Overflow: second edge while beat0 is stalled
    fa = {$urandom, $urandom, $urandom, $urandom};
    in_data = fa;
    out_if.out_ready = 1'b0;
    acc_done = 1'b1;
    push_frame(fa);
    cyc(1);
    acc_done = 1'b0;
    cyc(1);
    in_data = {$urandom, $urandom, $urandom, $urandom};
    acc_done = 1'b1;
    cyc(1);
    acc_done = 1'b0;
    check_eq("ovf_set", 64'(overflow), 64'd1);
    out_if.out_ready = 1'b1;
    wait_drain();
    check_eq("ovf_count", 64'(frame_count), 64'd5);
    check_eq("ovf_sticky", 64'(overflow), 64'd1);

    // Gating: edge with en low is lost, raising en on a held level does not capture
    en = 1'b0;
    acc_done = 1'b1;
    cyc(2);
    check_eq("gate_valid_en0", 64'(out_if.out_valid), 64'd0);
    en = 1'b1;
    cyc(2);
    check_eq("gate_valid_held", 64'(out_if.out_valid), 64'd0);
    acc_done = 1'b0;
    cyc(1);
    fa = {$urandom, $urandom, $urandom, $urandom};
    in_data = fa;
    acc_done = 1'b1;
    push_frame(fa);
    cyc(1);
    check_eq("gate_valid_fresh", 64'(out_if.out_valid), 64'd1);
    acc_done = 1'b0;
    wait_drain();
    check_eq("gate_count", 64'(frame_count), 64'd6);

    // Mid-frame reset, then capture on the first cycle with acc_done already high
    fa = {$urandom, $urandom, $urandom, $urandom};
    in_data = fa;
    out_if.out_ready = 1'b0;
    acc_done = 1'b1;
    push_frame(fa);
    cyc(1);
    check_eq("mid_valid", 64'(out_if.out_valid), 64'd1);
    rst_n = 1'b0;
    sb.delete();
    cyc(1);
    check_eq("mrst_valid", 64'(out_if.out_valid), 64'd0);
    check_eq("mrst_data", out_if.out_data, 64'd0);
    check_eq("mrst_idx", 64'(out_if.out_idx), 64'd0);
    check_eq("mrst_last", 64'(out_if.out_last), 64'd0);
    check_eq("mrst_busy", 64'(busy), 64'd0);
    check_eq("mrst_overflow", 64'(overflow), 64'd0);
    check_eq("mrst_count", 64'(frame_count), 64'd0);
    fb = {$urandom, $urandom, $urandom, $urandom};
    in_data = fb;
    push_frame(fb);
    out_if.out_ready = 1'b1;
    rst_n = 1'b1;
    cyc(1);
    check_eq("post_rst_capture", 64'(out_if.out_valid), 64'd1);
    acc_done = 1'b0;
    wait_drain();
    check_eq("post_rst_count", 64'(frame_count), 64'd1);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/core_output_serializer.md
# core_output_serializer

Downstream stage of the multi-core matrix-multiply top level. It captures the concatenated `NUM_CORES` x (`WIDTH*CHUNK_SIZE`) result bus when the cores report accumulation complete. It then streams the result out one core chunk per beat over a valid/ready handshake, so later stages (buffer, memory writer) see a fixed `WIDTH*CHUNK_SIZE`-bit stream regardless of core count. It also flags results lost to back-pressure and counts delivered frames.

## Interface
Parameters:
- `WIDTH`, 16, element width in bits
- `CHUNK_SIZE`, 4, elements per core chunk; one beat = `WIDTH*CHUNK_SIZE` bits (64 by default)
- `NUM_CORES`, 2, number of chunks per frame; legal range 2..32
- `CNT_WIDTH`, 16, width of frame counter

Ports:
- `clk`, in, 1: single clock, all logic on rising edge
- `rst_n`, in, 1: synchronous, active-low reset
- `en`, in, 1: capture enable; gates new captures only
- `acc_done`, in, 1: level from top-level `accumulator_done`
- `in_data`, in, `WIDTH*CHUNK_SIZE*NUM_CORES`: top-level `out_top`; core i occupies bits `[(i+1)*WIDTH*CHUNK_SIZE-1 -: WIDTH*CHUNK_SIZE]`
- `out_ready`, in, 1: consumer ready
- `out_valid`, out, 1: beat valid
- `out_data`, out, `WIDTH*CHUNK_SIZE`: current chunk
- `out_last`, out, 1: high with the final beat of a frame (chunk `NUM_CORES-1`)
- `out_idx`, out, `$clog2(NUM_CORES)`: index of chunk on `out_data`
- `busy`, out, 1: frame held, not fully delivered
- `overflow`, out, 1: sticky; a capture edge was dropped
- `frame_count`, out, `CNT_WIDTH`: completed frames, wraps modulo 2^`CNT_WIDTH`

## Operation
- Edge detect: register `acc_done_d`. `cap = en & acc_done & ~acc_done_d`. `acc_done_d` updates every cycle regardless of `en`.
- FSM states:
  - IDLE: `out_valid`=0, `busy`=0. On `cap`: load shadow ← `in_data`, idx ← 0, go SEND.
  - SEND: `out_valid`=1, `busy`=1, `out_data` = shadow slice idx, `out_idx` = idx, `out_last` = (idx == `NUM_CORES-1`).
    - Handshake (`out_valid & out_ready`) with idx < `NUM_CORES-1`: idx+1, stay in SEND.
    - Handshake on the last beat: `frame_count`+1. If `cap` in the same cycle, reload shadow, idx ← 0, stay in SEND (back-to-back frame). Otherwise go IDLE.
    - `cap` without a last-beat handshake: shadow unchanged, `overflow` ← 1, new data discarded.
- Transmission order: chunk 0 (LSB slice) first, chunk `NUM_CORES-1` last.
- While `out_valid`=1 and `out_ready`=0: `out_data`, `out_idx` and `out_last` hold stable.
- `en`=0 does not stall an in-progress frame. An edge that occurs while `en`=0 is lost, and is not flagged as overflow.
- `out_data` is 0 in IDLE.
- Reset (any cycle, including mid-frame): state IDLE, idx 0, shadow 0, `acc_done_d` 0. All outputs 0: `out_valid`, `out_data`, `out_last`, `out_idx`, `busy`, `overflow`, `frame_count`. The partial frame is abandoned and not counted.
- `overflow` clears only on reset.

## Timing
- Capture: `acc_done` rises, sampled at edge T → shadow loaded at T. `out_valid`=1 in cycle T+1 with chunk 0.
- With `out_ready` held high, chunk k is presented in cycle T+1+k. The last beat is in cycle T+`NUM_CORES`. `out_valid` drops in cycle T+`NUM_CORES`+1.
- `frame_count` increments on the edge that completes the last handshake, visible the next cycle.
- `acc_done` held high for many cycles counts as one capture; it must return low before another capture is possible.
- `acc_done` already high when reset deasserts: edge detected on the first cycle (`acc_done_d`=0), provided `en`=1.
- `in_data` is sampled only on the capture edge. The upstream cores may change it afterwards.

## Test plan
- Basic frame (`NUM_CORES`=2): `in_data`={64'hBBBB_…_0002, 64'hAAAA_…_0001}, `acc_done` 0→1, `out_ready`=1 → beat0 = ..._0001 with `out_idx` 0; beat1 = ..._0002 with `out_last`=1; `frame_count`=1; `busy` low afterwards.
- Back-pressure: `out_ready` low 3 cycles after first valid → `out_data` stable for 3 cycles; beats delivered in order; no overflow.
- Overflow: second `acc_done` edge while beat0 is stalled → `overflow`=1; the original frame's data is still delivered intact; `frame_count`=1.
- Back-to-back: new edge coincident with the last-beat handshake → `out_valid` stays high; the next cycle shows the new chunk 0; `overflow`=0; `frame_count` reaches 2.
- Gating: edge with `en`=0 → no `out_valid`; `acc_done` held high, then `en` raised → still no capture. Drop `acc_done`, re-raise it with `en`=1 → frame sent.
- Mid-frame reset: `rst_n` low during beat0 → next cycle all outputs 0 and `frame_count` 0. After reset releases with `acc_done` already high → capture on the first cycle.
